imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator and address/target unit for the next-generation core.
- Extracts the I/S/B/U/J/JALR immediate, sign-extends it to XLEN, and adds it to the selected base (PC or rs1).
- Flags misaligned control-flow targets and illegal selects.
- Two registered stages with valid/ready handshake; sits between decode and execute/fetch-redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- IALIGN, 32, instruction alignment in bits; 32 checks target[1:0], 16 checks target[0].
- AUTO_DECODE, 0, 1 = derive select from instr[6:0] and ignore in_imm_sel.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- in_rs1  in  XLEN  rs1 operand
- in_imm_sel  in  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J, 101 JALR, 110/111 illegal
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_imm  out  XLEN  sign-extended immediate
- out_target  out  XLEN  base + imm
- out_misaligned  out  1  control-flow target violates IALIGN
- out_illegal  out  1  unsupported select or opcode

Behaviour:
- Reset: s1_valid, s2_valid, out_valid = 0; out_imm, out_target, out_misaligned, out_illegal = 0.
- Reset mid-operation drops in-flight beats with no output.
- in_ready stays low during the reset cycle.
- Stage 1 (on accept): register the select, the extracted and sign-extended immediate, and the base.
- Immediate extraction:
  - I/JALR: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All types sign-extend from instr[31] to XLEN, including U on XLEN=64.
- Base select: rs1 for I, S, JALR; pc for B, U, J.
- Stage 2: target = base + imm, modulo 2^XLEN (wraps silently).
  - JALR clears target[0] after the add.
  - Misaligned is evaluated only for B, J, JALR, after the JALR clear; it is 0 for other types.
  - Illegal select forces imm = 0, target = 0, illegal = 1, misaligned = 0.
- AUTO_DECODE opcode map: 0010011/0000011/1110011 -> I, 1100111 -> JALR, 0100011 -> S, 1100011 -> B, 0110111/0010111 -> U, 1101111 -> J, anything else -> illegal.
- Handshake:
  - s1_adv = !s2_valid || out_ready
  - in_ready = !s1_valid || s1_adv
  - A beat transfers on valid && ready at both ports.
  - Full throughput of 1 beat/cycle.
  - Latency is exactly 2 cycles from input accept to out_valid when out_ready is held high.
- Backpressure: with out_ready low, the outputs hold stable and in_ready deasserts once both stages are full.
  - At most 2 beats are buffered; order is preserved; no drop or duplication.
- Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
- out_valid must not depend combinationally on out_ready.

Decomposition:
- Package imm_gen_pkg holds:
  - imm_sel_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_JALR)
  - opcode constants (OP_IMM, OP_LOAD, OP_SYSTEM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - the opcode-to-select decode function
- Sub-module imm_extract: combinational instr + sel -> XLEN immediate plus illegal flag. It is instantiated in stage 1.

Test Plan:
- XLEN=32, sel I, instr 0xFFF00093, rs1=0x100 -> 2 cycles later: imm 0xFFFFFFFF, target 0x000000FF, misaligned 0, illegal 0.
- Sel B, instr 0xFE000EE3, pc=0x1000 -> imm 0xFFFFFFFC, target 0x00000FFC, misaligned 0.
- IALIGN=32, checks on J and JALR:
  - J, instr 0x0020006F, pc=0x2000 -> target 0x2002, misaligned 1.
  - JALR, instr 0x00308067, rs1=0x1000 -> target 0x1002, misaligned 1.
  - Same two cases with IALIGN=16 -> misaligned 0.
- XLEN=64, AUTO_DECODE=1, instr 0x800000B7 (LUI) -> imm 0xFFFFFFFF80000000, illegal 0; instr opcode 0x7F -> illegal 1, imm 0, target 0.
- Backpressure: issue 4 beats back-to-back with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - After out_ready rises, all 4 results appear in order, none lost or duplicated.
- Assert rst with 2 beats in flight -> next cycle out_valid=0 and all outputs 0; the first post-reset beat emerges with 2-cycle latency.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and select helpers for the immediate generator.
package imm_gen_pkg;

    // Immediate types; the encodings match the external in_imm_sel field.
    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_JALR = 3'b101
    } imm_sel_t;

    // Select value used internally for anything that has no immediate format.
    localparam logic [2:0] SEL_ILLEGAL = 3'b111;

    // Major opcodes (instr[6:0]) recognised by the automatic decoder.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Maps a major opcode onto its immediate format; unknown opcodes become illegal.
    function automatic logic [2:0] decode_opcode(input logic [6:0] opcode);
        logic [2:0] sel;
        sel = SEL_ILLEGAL;
        case (opcode)
            OP_IMM, OP_LOAD, OP_SYSTEM: sel = IMM_I;
            OP_JALR:                    sel = IMM_JALR;
            OP_STORE:                   sel = IMM_S;
            OP_BRANCH:                  sel = IMM_B;
            OP_LUI, OP_AUIPC:           sel = IMM_U;
            OP_JAL:                     sel = IMM_J;
            default:                    sel = SEL_ILLEGAL;
        endcase
        return sel;
    endfunction

    // Register-relative formats add to rs1; all others are PC-relative.
    function automatic logic uses_rs1_base(input logic [2:0] sel);
        return (sel == IMM_I) || (sel == IMM_S) || (sel == IMM_JALR);
    endfunction

    // Only control-flow formats produce a target whose alignment matters.
    function automatic logic is_ctrl_flow(input logic [2:0] sel);
        return (sel == IMM_B) || (sel == IMM_J) || (sel == IMM_JALR);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: gathers the scattered immediate bits of
// each instruction format and sign-extends from instr[31] to XLEN. The opcode
// bits are not part of any immediate, so only instr[31:7] is taken.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] raw;

    // Build a 32-bit sign-extended immediate per format, then widen to XLEN.
    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (sel)
            IMM_I, IMM_JALR: raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:           raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:           raw = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            IMM_U:           raw = {instr[31:12], 12'b0};
            IMM_J:           raw = {{11{instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            default:         illegal = 1'b1;
        endcase
        imm = XLEN'($signed(raw));
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator and address/target unit. Stage 1 captures the
// select, the sign-extended immediate and the chosen base; stage 2 forms the
// target, flags misalignment and illegal selects, and drives the outputs.
// A valid/ready handshake with one-register-per-stage buffering gives full
// throughput and holds results stable under backpressure.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IALIGN      = 32,
    parameter int AUTO_DECODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_misaligned,
    output logic            out_illegal
);

    logic            s1_valid;
    logic            s2_valid;
    logic            s1_adv;
    logic            in_accept;

    logic [2:0]      in_sel;
    logic [XLEN-1:0] in_base;
    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    logic [2:0]      s1_sel;
    logic [XLEN-1:0] s1_imm;
    logic [XLEN-1:0] s1_base;
    logic            s1_illegal;

    logic [XLEN-1:0] s2_imm_d;
    logic [XLEN-1:0] s2_target_d;
    logic            s2_mis_d;
    logic            s2_ill_d;

    assign in_sel  = (AUTO_DECODE != 0) ? decode_opcode(in_instr[6:0]) : in_imm_sel;
    assign in_base = uses_rs1_base(in_sel) ? in_rs1 : in_pc;

    // Stage 1 may advance whenever stage 2 is empty or being drained; the
    // input side is open whenever stage 1 is empty or moving on. Neither
    // depends on out_valid, so out_valid never sees out_ready combinationally.
    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !rst && (!s1_valid || s1_adv);
    assign in_accept = in_valid && in_ready;
    assign out_valid = s2_valid;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr  (in_instr[31:7]),
        .sel    (in_sel),
        .imm    (ext_imm),
        .illegal(ext_illegal)
    );

    // Stage 1 register: refills (or empties) whenever the input side is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sel     <= IMM_I;
            s1_imm     <= '0;
            s1_base    <= '0;
            s1_illegal <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_accept) begin
                s1_sel     <= in_sel;
                s1_imm     <= ext_imm;
                s1_base    <= in_base;
                s1_illegal <= ext_illegal;
            end
        end
    end

    // Target formation: wrap-around add, JALR LSB clear, then alignment check.
    always_comb begin
        s2_imm_d    = s1_imm;
        s2_target_d = s1_base + s1_imm;
        s2_mis_d    = 1'b0;
        s2_ill_d    = 1'b0;
        if (s1_sel == IMM_JALR) begin
            s2_target_d[0] = 1'b0;
        end
        if (is_ctrl_flow(s1_sel)) begin
            s2_mis_d = (IALIGN == 32) ? (s2_target_d[1:0] != 2'b00) : s2_target_d[0];
        end
        if (s1_illegal) begin
            s2_imm_d    = '0;
            s2_target_d = '0;
            s2_mis_d    = 1'b0;
            s2_ill_d    = 1'b1;
        end
    end

    // Stage 2 / output register: only loads when the consumer side allows it,
    // so the outputs hold steady while out_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid       <= 1'b0;
            out_imm        <= '0;
            out_target     <= '0;
            out_misaligned <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_imm        <= s2_imm_d;
                out_target     <= s2_target_d;
                out_misaligned <= s2_mis_d;
                out_illegal    <= s2_ill_d;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. Three instances share one input stream:
// XLEN=32/IALIGN=32, XLEN=32/IALIGN=16, and XLEN=64 with automatic decode.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        mis;
        logic        ill;
    } res_t;

    typedef struct packed {
        res_t r2;
        res_t r1;
        res_t r0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_sel;
    logic [63:0] in_pc;
    logic [63:0] in_rs1;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] out_imm0, out_target0, out_imm1, out_target1;
    logic [63:0] out_imm2, out_target2;
    logic        mis0, mis1, mis2, ill0, ill1, ill2;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   occ = 0;
    int   recv_cnt = 0;
    exp_t exp_q[$];

    bit          rand_done;
    logic [31:0] r_instr;
    logic [2:0]  r_sel;
    logic [63:0] r_pc, r_rs1;
    logic [6:0]  ops [10];
    logic [31:0] dv_instr [10];
    logic [2:0]  dv_sel [10];
    logic [63:0] dv_pc [10];
    logic [63:0] dv_rs1 [10];
    int          rx0;
    int          t0;
    int          n;

    imm_gen_pipe #(.XLEN(32), .IALIGN(32), .AUTO_DECODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_rs1(in_rs1[31:0]),
        .in_imm_sel(in_imm_sel), .out_valid(out_valid0), .out_ready(out_ready),
        .out_imm(out_imm0), .out_target(out_target0),
        .out_misaligned(mis0), .out_illegal(ill0)
    );

    imm_gen_pipe #(.XLEN(32), .IALIGN(16), .AUTO_DECODE(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_rs1(in_rs1[31:0]),
        .in_imm_sel(in_imm_sel), .out_valid(out_valid1), .out_ready(out_ready),
        .out_imm(out_imm1), .out_target(out_target1),
        .out_misaligned(mis1), .out_illegal(ill1)
    );

    imm_gen_pipe #(.XLEN(64), .IALIGN(32), .AUTO_DECODE(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1),
        .in_imm_sel(in_imm_sel), .out_valid(out_valid2), .out_ready(out_ready),
        .out_imm(out_imm2), .out_target(out_target2),
        .out_misaligned(mis2), .out_illegal(ill2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of one beat for a given instance configuration.
    function automatic res_t model(input logic [31:0] instr, input logic [2:0] sel_in,
                                   input logic [63:0] pc, input logic [63:0] rs1,
                                   input int xlen, input int ialign, input bit auto_dec);
        res_t        r;
        logic [2:0]  sel;
        logic [31:0] i32;
        logic [63:0] base;
        r   = '0;
        i32 = '0;
        sel = sel_in;
        if (auto_dec) begin
            case (instr[6:0])
                7'h13, 7'h03, 7'h73: sel = 3'd0;
                7'h67:               sel = 3'd5;
                7'h23:               sel = 3'd1;
                7'h63:               sel = 3'd2;
                7'h37, 7'h17:        sel = 3'd3;
                7'h6F:               sel = 3'd4;
                default:             sel = 3'd7;
            endcase
        end
        case (sel)
            3'd0, 3'd5: i32 = {{20{instr[31]}}, instr[31:20]};
            3'd1:       i32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2:       i32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3:       i32 = {instr[31:12], 12'h000};
            3'd4:       i32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: begin
                r.ill = 1'b1;
                return r;
            end
        endcase
        r.imm = {{32{i32[31]}}, i32};
        base  = (sel == 3'd0 || sel == 3'd1 || sel == 3'd5) ? rs1 : pc;
        r.tgt = base + r.imm;
        if (xlen == 32) begin
            r.imm[63:32] = '0;
            r.tgt[63:32] = '0;
        end
        if (sel == 3'd5) r.tgt[0] = 1'b0;
        if (sel == 3'd2 || sel == 3'd4 || sel == 3'd5)
            r.mis = (ialign == 32) ? (r.tgt[1:0] != 2'b00) : r.tgt[0];
        return r;
    endfunction

    function automatic exp_t expectAll(input logic [31:0] instr, input logic [2:0] sel,
                                       input logic [63:0] pc, input logic [63:0] rs1);
        exp_t e;
        e.r0 = model(instr, sel, pc, rs1, 32, 32, 1'b0);
        e.r1 = model(instr, sel, pc, rs1, 32, 16, 1'b0);
        e.r2 = model(instr, sel, pc, rs1, 64, 32, 1'b1);
        return e;
    endfunction

    task automatic compareBeat(input exp_t e);
        checkOutput("imm_x32",    64'(out_imm0),    e.r0.imm);
        checkOutput("target_x32", 64'(out_target0), e.r0.tgt);
        checkOutput("mis_x32",    64'(mis0),        64'(e.r0.mis));
        checkOutput("ill_x32",    64'(ill0),        64'(e.r0.ill));
        checkOutput("valid_a16",  64'(out_valid1),  64'd1);
        checkOutput("imm_a16",    64'(out_imm1),    e.r1.imm);
        checkOutput("target_a16", 64'(out_target1), e.r1.tgt);
        checkOutput("mis_a16",    64'(mis1),        64'(e.r1.mis));
        checkOutput("ill_a16",    64'(ill1),        64'(e.r1.ill));
        checkOutput("valid_x64",  64'(out_valid2),  64'd1);
        checkOutput("imm_x64",    out_imm2,         e.r2.imm);
        checkOutput("target_x64", out_target2,      e.r2.tgt);
        checkOutput("mis_x64",    64'(mis2),        64'(e.r2.mis));
        checkOutput("ill_x64",    64'(ill2),        64'(e.r2.ill));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 64'({out_valid0, out_valid1, out_valid2}), 64'd0);
        checkOutput({tag, "_imm"},   64'(out_imm0) | 64'(out_imm1) | out_imm2, 64'd0);
        checkOutput({tag, "_tgt"},   64'(out_target0) | 64'(out_target1) | out_target2, 64'd0);
        checkOutput({tag, "_flags"}, 64'({mis0, mis1, mis2, ill0, ill1, ill2}), 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks in_ready against an occupancy model, pushes expected
    // results on accept and pops/compares them on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        logic acc;
        logic drn;
        if (rst) begin
            checkOutput("rst_in_ready", 64'(in_ready0), 64'd0);
            occ <= 0;
        end else begin
            acc = in_valid && in_ready0;
            drn = out_valid0 && out_ready;
            checkOutput("in_ready_x32", 64'(in_ready0), 64'((occ < 2) || out_ready));
            checkOutput("in_ready_a16", 64'(in_ready1), 64'((occ < 2) || out_ready));
            checkOutput("in_ready_x64", 64'(in_ready2), 64'((occ < 2) || out_ready));
            if (acc) exp_q.push_back(expectAll(in_instr, in_imm_sel, in_pc, in_rs1));
            if (drn) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    compareBeat(e);
                    recv_cnt <= recv_cnt + 1;
                end
            end
            occ <= occ + int'(acc) - int'(drn);
        end
    end

    task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] sel,
                                 input logic [63:0] pc, input logic [63:0] rs1);
        int   k;
        logic acc;
        in_instr   = instr;
        in_imm_sel = sel;
        in_pc      = pc;
        in_rs1     = rs1;
        in_valid   = 1'b1;
        k   = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ops      = '{7'h13, 7'h03, 7'h73, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        dv_instr = '{32'hFFF00093, 32'hFE000EE3, 32'h0020006F, 32'h00308067, 32'h800000B7,
                     32'h0000007F, 32'h00112223, 32'h12345017, 32'h0000007F, 32'h00100093};
        dv_sel   = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd1, 3'd3, 3'd7, 3'd0};
        dv_pc    = '{64'h0, 64'h1000, 64'h2000, 64'h0, 64'h0,
                     64'h40, 64'h0, 64'h100, 64'h80, 64'h0};
        dv_rs1   = '{64'h100, 64'h0, 64'h0, 64'h1000, 64'h0,
                     64'h44, 64'h200, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_instr   = '0;
        in_imm_sel = '0;
        in_pc      = '0;
        in_rs1     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst       = 1'b0;
        out_ready = 1'b1;

        $display("[TB] directed vectors");
        for (int k = 0; k < 10; k++) applyStimulus(dv_instr[k], dv_sel[k], dv_pc[k], dv_rs1[k]);
        drain();

        $display("[TB] random beats with random out_ready");
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    r_instr      = $urandom();
                    r_instr[6:0] = ops[$urandom_range(0, 9)];
                    r_sel        = 3'($urandom_range(0, 7));
                    r_pc         = {$urandom(), $urandom()};
                    r_rs1        = {$urandom(), $urandom()};
                    applyStimulus(r_instr, r_sel, r_pc, r_rs1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] backpressure");
        rx0       = recv_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    applyStimulus({12'(k + 1), 5'd0, 3'b000, 5'd1, 7'h13}, 3'd0,
                                  64'h3000, 64'(32'h10 * (k + 1)));
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("bp_in_ready_%0d", i), 64'(in_ready0), 64'(i < 2));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checkOutput("bp_count", 64'(recv_cnt - rx0), 64'd4);

        $display("[TB] reset with beats in flight");
        applyStimulus(32'h00500093, 3'd0, 64'h0, 64'h10);
        applyStimulus(32'h00600093, 3'd0, 64'h0, 64'h20);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        checkAllZero("rst_mid");
        rst        = 1'b0;
        in_instr   = 32'h0070006F;
        in_imm_sel = 3'd4;
        in_pc      = 64'h4000;
        in_rs1     = 64'h0;
        in_valid   = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_accept", 64'(in_ready0), 64'd1);
        t0 = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("post_rst_latency", 64'(cyc - t0), 64'd2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
